// File: rtl/pim_vector_sequencer.sv
// Processing-in-memory vector sequencer: walks two SRAM operand vectors one element
// at a time (READ, EXEC, WRITE) and writes the element-wise ALU result back to SRAM.
module pim_vector_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_src1,
  input  logic [ADDR_WIDTH-1:0] cmd_src2,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  output logic [ADDR_WIDTH-1:0] sram_read_addr1,
  output logic [ADDR_WIDTH-1:0] sram_read_addr2,
  input  logic [DATA_WIDTH-1:0] sram_read_data1,
  input  logic [DATA_WIDTH-1:0] sram_read_data2,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_write_addr,
  output logic [DATA_WIDTH-1:0] sram_write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] EXEC  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [2:0]            state;
  logic [2:0]            state_next;
  logic [2:0]            op_q;
  logic                  illegal_q;
  logic [ADDR_WIDTH-1:0] src1_q;
  logic [ADDR_WIDTH-1:0] src2_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] idx_inc;
  logic [ADDR_WIDTH-1:0] rd_addr1;
  logic [ADDR_WIDTH-1:0] rd_addr2;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  accept;
  logic                  cmd_illegal;
  logic                  last_elem;

  assign accept      = cmd_valid && (state == IDLE);
  assign cmd_illegal = (cmd_op[2:1] == 2'b11);
  assign idx_inc     = idx + ONE;
  assign last_elem   = (idx_inc == len_q);

  assign cmd_ready       = (state == IDLE);
  assign busy            = (state != IDLE);
  assign sram_we         = (state == WRITE);
  assign done            = (state == FIN);
  assign err             = (state == FIN) && illegal_q;
  assign sram_read_addr1 = rd_addr1;
  assign sram_read_addr2 = rd_addr2;
  assign sram_write_addr = wr_addr;
  assign sram_write_data = result;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_illegal || (cmd_len == '0)) state_next = FIN;
          else                                state_next = READ;
        end
      end
      READ:    state_next = EXEC;
      EXEC:    state_next = WRITE;
      WRITE:   state_next = last_elem ? FIN : READ;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Illegal opcodes never reach EXEC, so the default arm is unreachable in practice.
  always_comb begin
    alu_out = '0;
    case (op_q)
      OP_ADD:  alu_out = op_a + op_b;
      OP_SUB:  alu_out = op_a - op_b;
      OP_MUL:  alu_out = op_a * op_b;
      OP_AND:  alu_out = op_a & op_b;
      OP_OR:   alu_out = op_a | op_b;
      OP_XOR:  alu_out = op_a ^ op_b;
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      idx       <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q      <= cmd_op;
        illegal_q <= cmd_illegal;
        src1_q    <= cmd_src1;
        src2_q    <= cmd_src2;
        dst_q     <= cmd_dst;
        len_q     <= cmd_len;
        idx       <= '0;
      end else if ((state == WRITE) && !last_elem) begin
        idx <= idx_inc;
      end
    end
  end

  // Read addresses are loaded on entry to READ and then simply held, so the
  // next element's read always follows the previous element's write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr1 <= '0;
      rd_addr2 <= '0;
      wr_addr  <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
    end else begin
      if (accept && !cmd_illegal && (cmd_len != '0)) begin
        rd_addr1 <= cmd_src1;
        rd_addr2 <= cmd_src2;
      end else if ((state == WRITE) && !last_elem) begin
        rd_addr1 <= src1_q + idx_inc;
        rd_addr2 <= src2_q + idx_inc;
      end
      if (state == READ) begin
        op_a <= sram_read_data1;
        op_b <= sram_read_data2;
      end
      if (state == EXEC) begin
        result  <= alu_out;
        wr_addr <= dst_q + idx;
      end
    end
  end

endmodule

// File: doc/pim_vector_sequencer.md
PIM_VECTOR_SEQUENCER -- requirements
Module: pim_vector_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, SRAM word width.
REQ-003 SHALL have one clock and asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  async active-low reset.
REQ-004 SHALL have ports: cmd_valid  input  1  command offered; cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-005 SHALL have ports: cmd_op  input  3  opcode; cmd_src1, cmd_src2, cmd_dst  input  ADDR_WIDTH  base addresses; cmd_len  input  ADDR_WIDTH  element count.
REQ-006 SHALL have ports: sram_read_addr1, sram_read_addr2  output  ADDR_WIDTH; sram_read_data1, sram_read_data2  input  DATA_WIDTH (combinational SRAM read).
REQ-007 SHALL have ports: sram_we  output  1; sram_write_addr  output  ADDR_WIDTH; sram_write_data  output  DATA_WIDTH.
REQ-008 SHALL have ports: busy  output  1  command in progress; done  output  1  one-cycle completion pulse; err  output  1  one-cycle illegal-opcode pulse.

Function
REQ-009 SHALL implement states IDLE, READ, EXEC, WRITE, FIN.
REQ-010 SHALL drive cmd_ready=1 only in IDLE; cmd_valid&&cmd_ready latches op, src1, src2, dst, len; element index i cleared to 0.
REQ-011 SHALL transition from IDLE on accept: op illegal -> FIN with err; len==0 -> FIN without err; else -> READ.
REQ-012 In READ SHALL drive sram_read_addr1=src1+i, sram_read_addr2=src2+i (mod 2^ADDR_WIDTH) and register both read data words into operand registers; -> EXEC.
REQ-013 In EXEC SHALL register result = f(opA,opB) truncated to DATA_WIDTH; -> WRITE.
REQ-014 Opcodes SHALL be: 000 ADD, 001 SUB (A-B), 010 MUL (low DATA_WIDTH bits), 011 AND, 100 OR, 101 XOR; 110 and 111 illegal.
REQ-015 In WRITE SHALL assert sram_we=1 for exactly one cycle with sram_write_addr=dst+i (mod 2^ADDR_WIDTH), sram_write_data=result; then i+1==len -> FIN, else i<=i+1 and -> READ.
REQ-016 In FIN SHALL pulse done=1 (err=1 also if illegal op) for one cycle; -> IDLE.
REQ-017 Per-element latency SHALL be 3 cycles (READ, EXEC, WRITE); a len=N command SHALL occupy 3N+1 cycles from accept to done, done on the cycle after the last write.
REQ-018 Next element's READ SHALL follow the previous WRITE, so an in-place or overlapping destination sees already-written data (read-after-write ordering by construction).
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 sram_we SHALL be 0 in all states except WRITE; read addresses SHALL be don't-care outside READ but held at last driven value.
REQ-021 cmd_* inputs SHALL be ignored outside IDLE; changes mid-command SHALL have no effect.
REQ-022 Address sums SHALL wrap silently at 2^ADDR_WIDTH; no error is raised.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, i=0, sram_we=0, done=0, err=0, busy=0, operand/result registers and all address outputs to 0.
REQ-024 Reset asserted mid-command SHALL abort it with no further SRAM write and no done pulse; cmd_ready=1 on the first clock after rst_n deasserts.

Verification
REQ-025 ADD, src1=0, src2=16, dst=32, len=4, mem[0..3]=1..4, mem[16..19]=10..40 -> mem[32..35]=11,22,33,44; done at cycle 13 after accept.
REQ-026 MUL, DATA_WIDTH=32, A=0x0001_0000, B=0x0001_0000, len=1 -> written 0x0000_0000; SUB 5-7 -> 0xFFFF_FFFE.
REQ-027 cmd_op=110, len=5 -> no sram_we ever, done and err pulse together one cycle after accept.
REQ-028 src1=1022, dst=1023, len=3 (ADDR_WIDTH=10) -> reads 1022,1023,0; writes 1023,0,1; in-place chain (dst=src1+1, ADD with B=1) yields incrementing values.
REQ-029 len=0 -> done without err one cycle after accept, no write; cmd_valid held high back-to-back -> second command accepted the cycle after done.
REQ-030 rst_n pulsed low during second element's EXEC -> sram_we stays 0, no done, busy=0 immediately, first element's write retained.
